// File: rtl/asteroids_pkg.sv
// Shared ship/renderer constants and control-decode helpers.
// Heading 0 points up; headings increase counter-clockwise.
package asteroids_pkg;

  localparam int HEADING_W = 4;
  localparam int SPEED_W   = 3;
  localparam int SPEED_MAX = 7;

  localparam logic [HEADING_W-1:0] HEADING_UP = '0;

  typedef enum logic [1:0] {
    ROT_NONE,
    ROT_LEFT,
    ROT_RIGHT
  } rot_e;

  typedef enum logic [1:0] {
    THR_COAST,
    THR_FWD,
    THR_BACK
  } thr_e;

  // Exactly one rotate key selects a direction
  function automatic rot_e rot_sel(
    input logic l,
    input logic r
  );
    rot_e v;
    v = ROT_NONE;
    unique case (1'b1)
      (l & ~r): v = ROT_LEFT;
      (r & ~l): v = ROT_RIGHT;
      default:  v = ROT_NONE;
    endcase
    return v;
  endfunction

  // Forward+backward together counts as coasting
  function automatic thr_e thr_sel(
    input logic f,
    input logic b
  );
    thr_e v;
    v = THR_COAST;
    unique case (1'b1)
      (f & ~b): v = THR_FWD;
      (b & ~f): v = THR_BACK;
      default:  v = THR_COAST;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ship_control_edge_detect.sv
// Rising-edge detector for held key levels.
// prev resets high so a key held through reset gives no edge.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Track last sampled level
  always_comb begin
    prev_d = d;
  end

  // Previous-level register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/ship_control.sv
// Ship kinematics (heading/speed) and fire/start arbitration.
// Motion state moves only on frame_tick.
module ship_control
  import asteroids_pkg::*;
#(
  parameter int ROT_PERIOD    = 4,
  parameter int DECAY_PERIOD  = 8,
  parameter int FIRE_COOLDOWN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 forward,
  input  logic                 backward,
  input  logic                 left_rotate,
  input  logic                 right_rotate,
  input  logic                 shoot,
  input  logic                 enter,
  input  logic                 bullet_ready,
  output logic [HEADING_W-1:0] heading,
  output logic [SPEED_W-1:0]   speed,
  output logic                 thrusting,
  output logic                 fire,
  output logic                 start
);

  localparam int ROT_W =
    (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;
  localparam int DEC_W =
    (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);

  localparam logic [ROT_W-1:0] ROT_RELOAD =
    ROT_W'(ROT_PERIOD - 1);
  localparam logic [DEC_W-1:0] DEC_LAST =
    DEC_W'(DECAY_PERIOD - 1);
  localparam logic [CD_W-1:0] CD_LOAD =
    CD_W'(FIRE_COOLDOWN);
  localparam logic [SPEED_W-1:0] SPD_MAX =
    SPEED_W'(SPEED_MAX);

  logic [HEADING_W-1:0] heading_q, heading_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic [ROT_W-1:0]     rot_cnt_q, rot_cnt_d;
  logic [DEC_W-1:0]     decay_cnt_q, decay_cnt_d;
  logic [CD_W-1:0]      cooldown_q, cooldown_d;
  logic                 fire_pend_q, fire_pend_d;
  logic                 fire_q, fire_d;
  logic                 start_q, start_d;
  logic                 thrusting_q, thrusting_d;

  logic shoot_rise;
  logic enter_rise;
  rot_e rot;
  thr_e thr;

  edge_detect u_shoot_edge (
    .clk   (clk),
    .reset (reset),
    .d     (shoot),
    .rise  (shoot_rise)
  );

  edge_detect u_enter_edge (
    .clk   (clk),
    .reset (reset),
    .d     (enter),
    .rise  (enter_rise)
  );

  assign rot = rot_sel(left_rotate, right_rotate);
  assign thr = thr_sel(forward, backward);

  // Rate-limited heading steps; a fresh press steps at once
  always_comb begin
    heading_d = heading_q;
    rot_cnt_d = rot_cnt_q;
    if (frame_tick) begin
      case (rot)
        ROT_LEFT, ROT_RIGHT: begin
          if (rot_cnt_q == '0) begin
            if (rot == ROT_LEFT) begin
              heading_d = heading_q + 1'b1;
            end else begin
              heading_d = heading_q - 1'b1;
            end
            rot_cnt_d = ROT_RELOAD;
          end else begin
            rot_cnt_d = rot_cnt_q - 1'b1;
          end
        end
        default: begin
          rot_cnt_d = '0;
        end
      endcase
    end
  end

  // Saturating speed with slow decay while coasting
  always_comb begin
    speed_d     = speed_q;
    decay_cnt_d = decay_cnt_q;
    if (frame_tick) begin
      case (thr)
        THR_FWD: begin
          if (speed_q != SPD_MAX) begin
            speed_d = speed_q + 1'b1;
          end
          decay_cnt_d = '0;
        end
        THR_BACK: begin
          if (speed_q != '0) begin
            speed_d = speed_q - 1'b1;
          end
          decay_cnt_d = '0;
        end
        default: begin
          if (decay_cnt_q == DEC_LAST) begin
            decay_cnt_d = '0;
            if (speed_q != '0) begin
              speed_d = speed_q - 1'b1;
            end
          end else begin
            decay_cnt_d = decay_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Fire arbitration: one buffered press, gated by cooldown
  always_comb begin
    fire_d = fire_pend_q
           & (cooldown_q == '0)
           & bullet_ready;
    fire_pend_d = fire_pend_q & ~fire_d;
    if (shoot_rise) begin
      fire_pend_d = 1'b1;
    end
    cooldown_d = cooldown_q;
    if (fire_d) begin
      cooldown_d = CD_LOAD;
    end else if (frame_tick && cooldown_q != '0) begin
      cooldown_d = cooldown_q - 1'b1;
    end
  end

  // Registered flame and start pulse
  always_comb begin
    thrusting_d = forward & ~backward;
    start_d     = enter_rise;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      heading_q   <= HEADING_UP;
      speed_q     <= '0;
      rot_cnt_q   <= '0;
      decay_cnt_q <= '0;
      cooldown_q  <= '0;
      fire_pend_q <= 1'b0;
      fire_q      <= 1'b0;
      start_q     <= 1'b0;
      thrusting_q <= 1'b0;
    end else begin
      heading_q   <= heading_d;
      speed_q     <= speed_d;
      rot_cnt_q   <= rot_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      cooldown_q  <= cooldown_d;
      fire_pend_q <= fire_pend_d;
      fire_q      <= fire_d;
      start_q     <= start_d;
      thrusting_q <= thrusting_d;
    end
  end

  assign heading   = heading_q;
  assign speed     = speed_q;
  assign thrusting = thrusting_q;
  assign fire      = fire_q;
  assign start     = start_q;

endmodule

// File: tb/tb_ship_control.sv
// Scoreboard bench for ship_control.
// Stimulus pushes model predictions; a monitor pops and compares.
module tb_ship_control;
  import asteroids_pkg::*;

  localparam int RP   = 4;
  localparam int DP   = 8;
  localparam int FC   = 8;
  localparam int NDIR = 1 << HEADING_W;

  logic clk = 1'b0;
  logic reset;
  logic frame_tick;
  logic forward, backward;
  logic left_rotate, right_rotate;
  logic shoot, enter, bullet_ready;
  logic [HEADING_W-1:0] heading;
  logic [SPEED_W-1:0]   speed;
  logic thrusting, fire, start;

  always #5 clk = ~clk;

  ship_control #(
    .ROT_PERIOD    (RP),
    .DECAY_PERIOD  (DP),
    .FIRE_COOLDOWN (FC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .forward      (forward),
    .backward     (backward),
    .left_rotate  (left_rotate),
    .right_rotate (right_rotate),
    .shoot        (shoot),
    .enter        (enter),
    .bullet_ready (bullet_ready),
    .heading      (heading),
    .speed        (speed),
    .thrusting    (thrusting),
    .fire         (fire),
    .start        (start)
  );

  typedef struct {
    int h;
    int s;
    int t;
    int f;
    int st;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;
  int fire_cnt = 0;
  int start_cnt = 0;
  bit mon_en = 0;

  // reference model state
  int m_head, m_speed, m_held, m_coast, m_since;
  bit m_pend, m_sprev, m_eprev;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0d exp=%0d",
               n, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_head  = 0;
    m_speed = 0;
    m_held  = 0;
    m_coast = 0;
    m_since = FC;
    m_pend  = 0;
    m_sprev = 1;
    m_eprev = 1;
  endfunction

  // one clock of behaviour, from the current input levels
  function automatic void model_step();
    exp_t e;
    bit rise;
    bit fire_n;
    rise    = shoot && !m_sprev;
    m_sprev = shoot;
    e.st    = (enter && !m_eprev) ? 1 : 0;
    m_eprev = enter;
    fire_n  = m_pend && (m_since >= FC) && bullet_ready;
    m_pend  = rise || (m_pend && !fire_n);
    if (fire_n) m_since = 0;
    else if (frame_tick && m_since < FC) m_since++;
    if (frame_tick) begin
      if (left_rotate != right_rotate) begin
        if (m_held % RP == 0)
          m_head = (m_head + (left_rotate ? 1 : NDIR - 1)) % NDIR;
        m_held++;
      end else begin
        m_held = 0;
      end
      if (forward && !backward) begin
        if (m_speed < SPEED_MAX) m_speed++;
        m_coast = 0;
      end else if (backward && !forward) begin
        if (m_speed > 0) m_speed--;
        m_coast = 0;
      end else begin
        m_coast++;
        if (m_coast % DP == 0 && m_speed > 0) m_speed--;
      end
    end
    e.h = m_head;
    e.s = m_speed;
    e.t = (forward && !backward) ? 1 : 0;
    e.f = fire_n ? 1 : 0;
    q.push_back(e);
  endfunction

  // monitor: compares every clocked output snapshot
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        mon_e = q.pop_front();
        chk("heading", 32'(heading), 32'(mon_e.h));
        chk("speed", 32'(speed), 32'(mon_e.s));
        chk("thrusting", 32'(thrusting), 32'(mon_e.t));
        chk("fire", 32'(fire), 32'(mon_e.f));
        chk("start", 32'(start), 32'(mon_e.st));
        if (fire) fire_cnt++;
        if (start) start_cnt++;
      end
    end
  end

  task automatic step(input bit ft);
    @(negedge clk);
    frame_tick = ft;
    model_step();
    mon_en = 1;
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1);
      step(0);
      step(0);
      step(0);
    end
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, "_heading"}, 32'(heading), 32'd0);
    chk({n, "_speed"}, 32'(speed), 32'd0);
    chk({n, "_thrust"}, 32'(thrusting), 32'd0);
    chk({n, "_fire"}, 32'(fire), 32'd0);
    chk({n, "_start"}, 32'(start), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 0;
    frame_tick = 0;
    model_reset();
    model_step();
    mon_en = 1;
    @(posedge clk);
    #2;
  endtask

  // asynchronous reset in the middle of a cycle
  task automatic reset_mid(input string n);
    #1;
    reset = 1;
    mon_en = 0;
    q.delete();
    #1;
    chk_reset_vals(n);
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  int f0, s0;

  initial begin
    reset = 1;
    frame_tick = 0;
    forward = 0;
    backward = 0;
    left_rotate = 0;
    right_rotate = 0;
    shoot = 1;
    enter = 1;
    bullet_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("por");
    release_reset();

    // keys held through reset give no edges
    repeat (4) step(0);
    chk("held_no_fire", 32'(fire_cnt), 32'd0);
    chk("held_no_start", 32'(start_cnt), 32'd0);
    shoot = 0;
    enter = 0;
    step(0);
    step(0);
    f0 = fire_cnt;
    s0 = start_cnt;
    shoot = 1;
    enter = 1;
    repeat (3) step(0);
    chk("repress_fire", 32'(fire_cnt - f0), 32'd1);
    chk("repress_start", 32'(start_cnt - s0), 32'd1);
    shoot = 0;
    enter = 0;
    step(0);

    // rotation
    left_rotate = 1;
    ticks(9);
    chk("left9", 32'(heading), 32'd3);
    left_rotate = 0;
    ticks(1);
    right_rotate = 1;
    ticks(1);
    chk("right1", 32'(heading), 32'd2);
    repeat (2) begin
      right_rotate = 0;
      ticks(1);
      right_rotate = 1;
      ticks(1);
    end
    chk("to_zero", 32'(heading), 32'd0);
    right_rotate = 0;
    ticks(1);
    right_rotate = 1;
    ticks(1);
    chk("wrap", 32'(heading), 32'd15);
    right_rotate = 0;

    // speed
    forward = 1;
    ticks(10);
    chk("fwd_sat", 32'(speed), 32'd7);
    chk("fwd_thrust", 32'(thrusting), 32'd1);
    forward = 0;
    ticks(8);
    chk("decay8", 32'(speed), 32'd6);
    ticks(8);
    chk("decay16", 32'(speed), 32'd5);
    forward = 1;
    backward = 1;
    step(0);
    chk("both_thrust", 32'(thrusting), 32'd0);
    ticks(8);
    chk("both_decay", 32'(speed), 32'd4);
    forward = 0;
    backward = 0;

    // fire and cooldown buffering
    f0 = fire_cnt;
    shoot = 1;
    repeat (3) step(0);
    shoot = 0;
    step(0);
    step(0);
    chk("one_fire", 32'(fire_cnt - f0), 32'd1);
    ticks(3);
    shoot = 1;
    step(0);
    shoot = 0;
    ticks(4);
    chk("cd_hold", 32'(fire_cnt - f0), 32'd1);
    step(1);
    chk("cd_tick8", 32'(fire_cnt - f0), 32'd1);
    step(0);
    chk("cd_issue", 32'(fire), 32'd1);
    chk("cd_count", 32'(fire_cnt - f0), 32'd2);

    // bullet pool full
    bullet_ready = 0;
    ticks(9);
    f0 = fire_cnt;
    shoot = 1;
    step(0);
    shoot = 0;
    ticks(3);
    chk("br0_nofire", 32'(fire_cnt - f0), 32'd0);
    bullet_ready = 1;
    step(0);
    chk("br1_fire", 32'(fire), 32'd1);
    shoot = 1;
    step(0);
    shoot = 0;
    ticks(7);
    chk("br1_cd", 32'(fire_cnt - f0), 32'd1);
    step(1);
    step(0);
    chk("br1_cd_end", 32'(fire_cnt - f0), 32'd2);

    // reset mid-cooldown and mid-rotation
    left_rotate = 1;
    ticks(25);
    left_rotate = 0;
    chk("head6", 32'(heading), 32'd6);
    ticks(3);
    shoot = 1;
    step(0);
    shoot = 0;
    step(0);
    step(0);
    ticks(3);
    shoot = 1;
    step(0);
    shoot = 0;
    left_rotate = 1;
    f0 = fire_cnt;
    reset_mid("rst_mid");
    left_rotate = 0;
    ticks(12);
    chk("no_stale", 32'(fire_cnt - f0), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) forward = ~forward;
      if ($urandom_range(0, 15) == 0) backward = ~backward;
      if ($urandom_range(0, 11) == 0) left_rotate = ~left_rotate;
      if ($urandom_range(0, 11) == 0) right_rotate = ~right_rotate;
      if ($urandom_range(0, 5) == 0) shoot = ~shoot;
      if ($urandom_range(0, 9) == 0) enter = ~enter;
      if ($urandom_range(0, 7) == 0) bullet_ready = ~bullet_ready;
      if (i == 2000) reset_mid("rst_rand");
      step($urandom_range(0, 3) == 0);
    end

    step(0);
    mon_en = 0;
    @(posedge clk);
    #2;
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ship_control.md
# ship_control

Per-frame ship kinematics and fire arbitration, sitting directly downstream of `keyboard`. It consumes the held-level controls (`forward`, `backward`, `left_rotate`, `right_rotate`, `shoot`, `enter`) and converts them into rate-limited heading steps and a saturating speed. It also produces single-cycle `fire` and `start` pulses for the ship renderer, bullet pool and game FSM. All motion state advances only on the frame tick, so behaviour is independent of the clock frequency.

## Interface
- HEADING_W, 4: heading width; 2^HEADING_W directions, wraps
- SPEED_W, 3: speed width
- SPEED_MAX, 7: speed saturation value (≤ 2^SPEED_W−1)
- ROT_PERIOD, 4: frame ticks between heading steps while a rotate key is held
- DECAY_PERIOD, 8: frame ticks per speed decrement while coasting
- FIRE_COOLDOWN, 8: frame ticks after a shot before the next shot is allowed
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; single clock domain
- frame_tick  in  1  one-cycle pulse per video frame
- forward, backward, left_rotate, right_rotate, shoot, enter  in  1 each  held levels from `keyboard`
- bullet_ready  in  1  bullet pool has a free slot
- heading  out  HEADING_W  current direction; 0 = up, increments counter-clockwise
- speed  out  SPEED_W  current speed magnitude
- thrusting  out  1  forward held and backward not held (drives flame sprite)
- fire  out  1  one-cycle spawn request
- start  out  1  one-cycle pulse on the rising edge of `enter`

## Operation
- Reset values: heading 0, speed 0, thrusting 0, fire 0, start 0, cooldown 0, fire_pend 0, rot_cnt 0, decay_cnt 0, shoot_prev 1, enter_prev 1.
  - Because the prev registers reset to 1, a key held through reset must be released and re-pressed to produce an edge.
- Rotation is evaluated on frame_tick:
  - Exactly one of left_rotate/right_rotate held:
    - rot_cnt==0 → step heading (left +1, right −1, modulo 2^HEADING_W) and load rot_cnt=ROT_PERIOD−1.
    - Otherwise decrement rot_cnt.
  - Neither or both held → rot_cnt=0, no step. A fresh press therefore steps on its first tick.
- Speed is evaluated on frame_tick:
  - forward & ~backward → speed+1, saturating at SPEED_MAX; decay_cnt=0.
  - backward & ~forward → speed−1, saturating at 0; decay_cnt=0.
  - Otherwise (coasting) → decay_cnt increments. When it reaches DECAY_PERIOD−1, decay_cnt resets to 0 and speed decrements, saturating at 0.
- thrusting is registered every clk as forward & ~backward.
- Fire:
  - Rising edge of shoot (shoot & ~shoot_prev) sets fire_pend. Multiple edges do not accumulate.
  - fire is asserted when fire_pend & cooldown==0 & bullet_ready. That same edge clears fire_pend and loads cooldown=FIRE_COOLDOWN.
  - cooldown decrements on frame_tick while nonzero. When a load and a decrement coincide, the load wins.
  - A new shoot edge in the same cycle that fire issues re-sets fire_pend (set wins).
  - Holding shoot never auto-fires. A press made during cooldown is buffered and issues when cooldown expires.
- start: registered `enter & ~enter_prev`.

## Timing
- shoot first high in cycle 0 → fire_pend=1 in cycle 1 → fire=1 in cycle 2, provided cooldown==0 and bullet_ready in cycle 1. fire is high for exactly 1 cycle.
- enter first high in cycle 0 → start=1 in cycle 1 only.
- heading and speed change in the cycle after frame_tick and are otherwise stable.
- A buffered press issues 2 cycles after the frame_tick that brings cooldown to 0.
- Asynchronous reset mid-cooldown or mid-rotation forces every reset value immediately. A pending shot is discarded.

## Structure
- Shared `asteroids_pkg` holds HEADING_W, SPEED_W, SPEED_MAX and the heading-0 orientation constant. The renderer and bullet spawner use the same values.
- One sub-module, `edge_detect`: a rising-edge detector whose prev register resets to 1. It is instantiated for shoot and enter.
- Rotation, speed and cooldown counters stay in the top module.

## Test plan
- Hold left_rotate for 9 frame ticks from reset → heading steps on ticks 1, 5 and 9, giving heading=3. Then hold right for 1 tick → heading=2. From heading 0, one right tick → heading=15.
- Hold forward for 10 ticks → speed=7, thrusting=1. Release; after 8 ticks speed=6, after 16 ticks speed=5. Hold forward+backward → thrusting=0 and coast decay applies.
- With bullet_ready=1, pulse shoot high for 3 cycles → exactly one fire, at cycle 2. Re-press after 3 ticks → no fire until cooldown expires, then fire exactly 2 cycles after the 8th tick.
- bullet_ready=0 with a shot pending → no fire. Raise bullet_ready → fire one cycle later, and cooldown loads 8.
- Hold shoot and enter through reset deassertion → no fire and no start. Release and re-press → fire at +2 and start at +1.
- Assert reset while cooldown=5 and heading=6 → all outputs and counters return to their reset values immediately, with no stale fire afterwards.
